adder_tree_sequencer: RTL and testbench
=======================================

Name: adder_tree_sequencer

Overview:
- Control block that drives one 8-input FP32 adder tree and one 2-input FP32 accumulate adder, both start/finish handshaked.
- Sums a vector of num_chunks x 8 FP32 elements.
- Per chunk: captures 8 elements, pulses the tree start, waits for the tree finish, then folds the chunk sum into a running total through the accumulate adder.
- Sits between the matrix/vector memory fetch logic and the dot-product result path.

Parameters:
NI, 8, elements per chunk (tree fan-in)
DW, 32, element width (IEEE-754 single)
CW, 16, width of chunk count

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse, begin new vector sum
num_chunks  in  CW  chunk count, sampled on accepted start
chunk_data  in  NI*DW  8 packed elements, element 0 in bits [31:0]
chunk_valid  in  1  chunk_data valid
chunk_ready  out  1  sequencer accepts chunk this cycle
tree_start  out  1  start pulse to adder tree
tree_inputs  out  NI*DW  registered operands to tree
tree_finish  in  1  tree result-valid indication
tree_sum  in  DW  tree result
acc_start  out  1  start pulse to accumulate adder
acc_a  out  DW  running total operand
acc_b  out  DW  chunk sum operand
acc_finish  in  1  accumulate adder result-valid
acc_sum  in  DW  accumulate adder result
result  out  DW  final sum, held until next start
done  out  1  one-cycle pulse when result updates
busy  out  1  high from accepted start until done

Behaviour:
- Reset (async, active-high): state IDLE.
  - All outputs 0; internal total and chunk counter 0.
  - Reset mid-operation aborts immediately. Later tree_finish/acc_finish are ignored until the next start.
- Edge detection:
  - tree_finish and acc_finish are rising-edge detected with a registered previous value.
  - A level held for several cycles counts once.
- IDLE:
  - busy=0, chunk_ready=0.
  - start=1 with num_chunks=0 -> result=0, done pulses next cycle, stays IDLE.
  - start=1 with num_chunks>0 -> latch count, remaining=num_chunks, first=1, go to FETCH.
- FETCH:
  - chunk_ready=1.
  - On chunk_valid&chunk_ready: register chunk_data into tree_inputs, go to ISSUE.
- ISSUE:
  - tree_start=1 for exactly one cycle, go to WAIT_TREE.
  - tree_inputs stay stable until the tree finish edge, because the tree delays start internally by two cycles.
- WAIT_TREE: on tree_finish rising edge:
  - Capture tree_sum into chunk_reg and decrement remaining.
  - If first=1: total<=tree_sum, first<=0, go to CHECK. The accumulate adder is skipped.
  - Else go to ACC.
- ACC:
  - acc_a=total, acc_b=chunk_reg, acc_start=1 for one cycle, go to WAIT_ACC.
  - acc_a/acc_b are held until the acc_finish edge.
- WAIT_ACC: on acc_finish rising edge, total<=acc_sum, go to CHECK.
- CHECK:
  - remaining=0 -> result<=total, done=1 for one cycle, go to IDLE.
  - Else go to FETCH.
- start while busy is ignored; it does not restart and is not queued.
- chunk_valid outside FETCH is ignored (no accept).
- Latency per chunk = 1 (accept) + 1 (issue) + tree latency + 1 + (accumulate latency + 2 for non-first chunks) + 1 (check).
- No FP arithmetic inside this block; it only moves data. Counter decrements never wrap because the check happens before FETCH.
- busy=1 in every state except IDLE; done and busy deassert together.

Decomposition:
- Shared package: state encoding localparams (IDLE, FETCH, ISSUE, WAIT_TREE, ACC, WAIT_ACC, CHECK), NI, DW.
- One sub-module: finish_edge_detect (registered rising-edge detector with async reset), instantiated twice, for tree_finish and acc_finish.
- Adder tree and accumulate adder are instantiated by the parent, not inside this block.

Test Plan:
- Single chunk: num_chunks=1, chunk of eight 1.0 (0x3F800000), tree model returns 0x41000000 after 5 cycles -> no acc_start, result=0x41000000, one done pulse.
- Three chunks: tree model returns 8.0, 16.0, 24.0; acc model adds after 4 cycles -> exactly 2 acc_start pulses, result=0x42400000 (48.0).
- Zero length: start with num_chunks=0 -> done one cycle later, result=0, no tree_start.
- Backpressure and stability: chunk_valid low for 10 cycles in FETCH -> chunk_ready stays 1, no tree_start. tree_finish held high 3 cycles -> counted once. tree_inputs unchanged between tree_start and tree_finish.
- Start while busy: second start mid-WAIT_TREE -> ignored, result equals first vector's sum, single done.
- Reset mid-op: assert reset in WAIT_ACC -> all outputs 0 immediately. A late acc_finish is ignored. A new start with num_chunks=1 then completes correctly.

Source files
------------

// File: rtl/adder_tree_sequencer_pkg.sv
// Shared definitions for the adder tree sequencer: default geometry and state encoding.
package adder_tree_sequencer_pkg;

  // Default tree fan-in and element width (IEEE-754 single)
  localparam int NI = 8;
  localparam int DW = 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    ISSUE     = 3'd2,
    WAIT_TREE = 3'd3,
    ACC       = 3'd4,
    WAIT_ACC  = 3'd5,
    CHECK     = 3'd6
  } state_t;

endpackage

// File: rtl/adder_tree_sequencer_finish_edge_detect.sv
// Rising-edge detector for finish/result-valid levels coming back from the adders.
// A level held high for several cycles produces a single rise pulse.
module finish_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev_reg;

  // Remember last cycle's level so only the 0->1 transition is reported
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_reg <= 1'b0;
    end else begin
      prev_reg <= level;
    end
  end

  assign rise = level & ~prev_reg;

endmodule

// File: rtl/adder_tree_sequencer.sv
// Sequencer that sums num_chunks x NI FP32 elements by feeding one chunk at a
// time through an external adder tree and folding each chunk sum into a
// running total with an external 2-input accumulate adder. Data movement only.
module adder_tree_sequencer #(
  parameter int NI = adder_tree_sequencer_pkg::NI,
  parameter int DW = adder_tree_sequencer_pkg::DW,
  parameter int CW = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CW-1:0]    num_chunks,
  input  logic [NI*DW-1:0] chunk_data,
  input  logic             chunk_valid,
  output logic             chunk_ready,
  output logic             tree_start,
  output logic [NI*DW-1:0] tree_inputs,
  input  logic             tree_finish,
  input  logic [DW-1:0]    tree_sum,
  output logic             acc_start,
  output logic [DW-1:0]    acc_a,
  output logic [DW-1:0]    acc_b,
  input  logic             acc_finish,
  input  logic [DW-1:0]    acc_sum,
  output logic [DW-1:0]    result,
  output logic             done,
  output logic             busy
);

  import adder_tree_sequencer_pkg::*;

  state_t           state_reg, state_next;
  logic [CW-1:0]    remaining_reg;
  logic             first_reg;
  logic [DW-1:0]    total_reg;
  logic [DW-1:0]    chunk_reg;
  logic [NI*DW-1:0] tree_inputs_reg;
  logic [DW-1:0]    result_reg;
  logic             zero_done_reg;
  logic             done_check;
  logic             tree_rise;
  logic             acc_rise;

  finish_edge_detect u_tree_edge (
    .clk   (clk),
    .reset (reset),
    .level (tree_finish),
    .rise  (tree_rise)
  );

  finish_edge_detect u_acc_edge (
    .clk   (clk),
    .reset (reset),
    .level (acc_finish),
    .rise  (acc_rise)
  );

  // State register plus the datapath registers each state loads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      remaining_reg   <= '0;
      first_reg       <= 1'b0;
      total_reg       <= '0;
      chunk_reg       <= '0;
      tree_inputs_reg <= '0;
      result_reg      <= '0;
      zero_done_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      zero_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (num_chunks == '0) begin
              // Empty vector: report a zero sum without touching the adders
              result_reg    <= '0;
              zero_done_reg <= 1'b1;
            end else begin
              remaining_reg <= num_chunks;
              first_reg     <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (chunk_valid) begin
            tree_inputs_reg <= chunk_data;
          end
        end
        WAIT_TREE: begin
          if (tree_rise) begin
            chunk_reg     <= tree_sum;
            remaining_reg <= remaining_reg - 1'b1;
            // First chunk seeds the total directly; no accumulate needed
            if (first_reg) begin
              total_reg <= tree_sum;
              first_reg <= 1'b0;
            end
          end
        end
        WAIT_ACC: begin
          if (acc_rise) begin
            total_reg <= acc_sum;
          end
        end
        CHECK: begin
          if (remaining_reg == '0) begin
            result_reg <= total_reg;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and handshake strobes
  always_comb begin
    state_next  = state_reg;
    chunk_ready = 1'b0;
    tree_start  = 1'b0;
    acc_start   = 1'b0;
    done_check  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && (num_chunks != '0)) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        chunk_ready = 1'b1;
        if (chunk_valid) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        tree_start = 1'b1;
        state_next = WAIT_TREE;
      end
      WAIT_TREE: begin
        if (tree_rise) begin
          state_next = first_reg ? CHECK : ACC;
        end
      end
      ACC: begin
        acc_start  = 1'b1;
        state_next = WAIT_ACC;
      end
      WAIT_ACC: begin
        if (acc_rise) begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (remaining_reg == '0) begin
          done_check = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operands are held in registers, so they stay stable for the whole handshake
  assign tree_inputs = tree_inputs_reg;
  assign acc_a       = total_reg;
  assign acc_b       = chunk_reg;
  assign busy        = (state_reg != IDLE);
  assign done        = done_check | zero_done_reg;
  // The final total is presented in the same cycle as done, then held
  assign result      = done_check ? total_reg : result_reg;

endmodule

// File: tb/tb_adder_tree_sequencer.sv
// Directed self-checking bench for adder_tree_sequencer with simple tree and
// accumulate adder models driven from the falling clock edge.
module tb_adder_tree_sequencer;

  localparam int NI = 8;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int TREE_LAT = 5;
  localparam int ACC_LAT  = 4;

  logic             clk;
  logic             reset;
  logic             start;
  logic [CW-1:0]    num_chunks;
  logic [NI*DW-1:0] chunk_data;
  logic             chunk_valid;
  logic             chunk_ready;
  logic             tree_start;
  logic [NI*DW-1:0] tree_inputs;
  logic             tree_finish;
  logic [DW-1:0]    tree_sum;
  logic             acc_start;
  logic [DW-1:0]    acc_a;
  logic [DW-1:0]    acc_b;
  logic             acc_finish;
  logic [DW-1:0]    acc_sum;
  logic [DW-1:0]    result;
  logic             done;
  logic             busy;

  int checks = 0;
  int errors = 0;

  adder_tree_sequencer #(.NI(NI), .DW(DW), .CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_chunks  (num_chunks),
    .chunk_data  (chunk_data),
    .chunk_valid (chunk_valid),
    .chunk_ready (chunk_ready),
    .tree_start  (tree_start),
    .tree_inputs (tree_inputs),
    .tree_finish (tree_finish),
    .tree_sum    (tree_sum),
    .acc_start   (acc_start),
    .acc_a       (acc_a),
    .acc_b       (acc_b),
    .acc_finish  (acc_finish),
    .acc_sum     (acc_sum),
    .result      (result),
    .done        (done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [NI*DW-1:0] act, input logic [NI*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Hand-computed FP32 sums for the operand pairs used by the vectors
  function automatic logic [31:0] acc_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h41000000 && b == 32'h41800000) return 32'h41C00000;      // 8+16=24
    else if (a == 32'h41C00000 && b == 32'h41C00000) return 32'h42400000; // 24+24=48
    else if (a == 32'h41800000 && b == 32'h41800000) return 32'h42000000; // 16+16=32
    else if (a == 32'h41000000 && b == 32'h41000000) return 32'h41800000; // 8+8=16
    else return 32'hBAD0BAD0;
  endfunction

  // Tree model: eight equal elements, so the sum is element * 8 (exponent + 3)
  int               tree_cnt = 0;
  int               tree_hold = 1;
  int               t_cnt = 0;
  int               t_hold_left = 0;
  bit               t_pend = 0;
  logic [NI*DW-1:0] t_snap;

  always @(negedge clk) begin
    if (tree_finish) begin
      if (t_hold_left <= 1) tree_finish = 1'b0;
      else t_hold_left--;
    end
    if (t_pend) begin
      t_cnt--;
      if (t_cnt == 0) begin
        t_pend = 0;
        chk("tree_inputs_stable", tree_inputs, t_snap);
        tree_sum    = t_snap[31:0] + 32'h01800000;
        tree_finish = 1'b1;
        t_hold_left = tree_hold;
      end
    end
    if (tree_start) begin
      tree_cnt++;
      t_pend = 1;
      t_cnt  = TREE_LAT;
      t_snap = tree_inputs;
    end
  end

  // Accumulate adder model: one-cycle finish pulse ACC_LAT cycles after start
  int          acc_cnt = 0;
  int          a_cnt = 0;
  bit          a_pend = 0;
  logic [31:0] a_op, b_op;

  always @(negedge clk) begin
    if (acc_finish) acc_finish = 1'b0;
    if (a_pend) begin
      a_cnt--;
      if (a_cnt == 0) begin
        a_pend     = 0;
        acc_sum    = acc_model(a_op, b_op);
        acc_finish = 1'b1;
      end
    end
    if (acc_start) begin
      acc_cnt++;
      a_pend = 1;
      a_cnt  = ACC_LAT;
      a_op   = acc_a;
      b_op   = acc_b;
    end
  end

  // Done monitor
  int          done_cnt = 0;
  logic [31:0] result_cap = '0;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      result_cap = result;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    tree_cnt = 0;
    acc_cnt  = 0;
    done_cnt = 0;
  endtask

  task automatic pulse_start(input int n);
    start      = 1'b1;
    num_chunks = CW'(n);
    tick();
    start      = 1'b0;
  endtask

  task automatic feed_chunk(input logic [31:0] e, input string name);
    int guard = 0;
    while (!chunk_ready && guard < 200) begin
      tick();
      guard++;
    end
    chk({name, "_ready_timeout"}, NI*DW'(chunk_ready), NI*DW'(1));
    chunk_valid = 1'b1;
    chunk_data  = {NI{e}};
    tick();
    chunk_valid = 1'b0;
    chunk_data  = '0;
    chk({name, "_tree_inputs"}, tree_inputs, {NI{e}});
  endtask

  task automatic wait_done_check(input string name, input logic [31:0] exp_res,
                                 input int exp_tree, input int exp_acc);
    int guard = 0;
    while (done_cnt == 0 && guard < 400) begin
      tick();
      guard++;
    end
    chk({name, "_done_seen"}, NI*DW'(done_cnt > 0), NI*DW'(1));
    repeat (4) tick();
    $display("txn %s: result=%h done_pulses=%0d tree_starts=%0d acc_starts=%0d",
             name, result_cap, done_cnt, tree_cnt, acc_cnt);
    chk({name, "_done_count"}, NI*DW'(done_cnt), NI*DW'(1));
    chk({name, "_result_at_done"}, NI*DW'(result_cap), NI*DW'(exp_res));
    chk({name, "_result_held"}, NI*DW'(result), NI*DW'(exp_res));
    chk({name, "_tree_starts"}, NI*DW'(tree_cnt), NI*DW'(exp_tree));
    chk({name, "_acc_starts"}, NI*DW'(acc_cnt), NI*DW'(exp_acc));
    chk({name, "_busy_after"}, NI*DW'(busy), NI*DW'(0));
  endtask

  typedef struct {
    string            name;
    int               n;
    logic [2:0][31:0] elems;
    logic [31:0]      exp_res;
    int               exp_tree;
    int               exp_acc;
    int               hold;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{"single", 1, {32'h0, 32'h0, 32'h3F800000}, 32'h41000000, 1, 0, 1};
    vecs[1] = '{"three", 3, {32'h40400000, 32'h40000000, 32'h3F800000}, 32'h42400000, 3, 2, 3};
    vecs[2] = '{"zero", 0, {32'h0, 32'h0, 32'h0}, 32'h00000000, 0, 0, 1};
    vecs[3] = '{"two", 2, {32'h0, 32'h40000000, 32'h40000000}, 32'h42000000, 2, 1, 1};

    reset       = 1'b1;
    start       = 1'b0;
    num_chunks  = '0;
    chunk_data  = '0;
    chunk_valid = 1'b0;
    tree_finish = 1'b0;
    tree_sum    = '0;
    acc_finish  = 1'b0;
    acc_sum     = '0;
    repeat (2) tick();
    chk("rst_busy", NI*DW'(busy), '0);
    chk("rst_done", NI*DW'(done), '0);
    chk("rst_chunk_ready", NI*DW'(chunk_ready), '0);
    chk("rst_result", NI*DW'(result), '0);
    chk("rst_tree_inputs", tree_inputs, '0);
    reset = 1'b0;
    tick();

    // Table-driven vectors
    for (int v = 0; v < 4; v++) begin
      clear_counts();
      tree_hold = vecs[v].hold;
      pulse_start(vecs[v].n);
      if (vecs[v].n == 0) begin
        chk({vecs[v].name, "_zero_done_next"}, NI*DW'(done), NI*DW'(1));
        chk({vecs[v].name, "_zero_result"}, NI*DW'(result), '0);
      end else begin
        chk({vecs[v].name, "_busy_after_start"}, NI*DW'(busy), NI*DW'(1));
      end
      for (int c = 0; c < vecs[v].n; c++) begin
        feed_chunk(vecs[v].elems[c], vecs[v].name);
      end
      wait_done_check(vecs[v].name, vecs[v].exp_res, vecs[v].exp_tree, vecs[v].exp_acc);
    end

    // Backpressure: chunk_valid low while in FETCH, then a tree finish held 3 cycles
    begin
      bit ready_ok = 1;
      clear_counts();
      tree_hold = 3;
      pulse_start(1);
      for (int i = 0; i < 10; i++) begin
        if (!chunk_ready) ready_ok = 0;
        tick();
      end
      chk("bp_ready_held", NI*DW'(ready_ok), NI*DW'(1));
      chk("bp_no_tree_start", NI*DW'(tree_cnt), '0);
      feed_chunk(32'h40400000, "bp");
      wait_done_check("bp", 32'h41C00000, 1, 0);
      tree_hold = 1;
    end

    // Start while busy is ignored
    begin
      int guard = 0;
      clear_counts();
      pulse_start(1);
      feed_chunk(32'h3F800000, "busy_start");
      while (tree_cnt == 0 && guard < 50) begin
        tick();
        guard++;
      end
      pulse_start(3);
      wait_done_check("busy_start", 32'h41000000, 1, 0);
      chk("busy_start_idle_ready", NI*DW'(chunk_ready), '0);
    end

    // Reset while waiting on the accumulate adder
    begin
      int guard = 0;
      clear_counts();
      pulse_start(2);
      feed_chunk(32'h3F800000, "rst_mid");
      feed_chunk(32'h3F800000, "rst_mid");
      while (acc_cnt == 0 && guard < 100) begin
        tick();
        guard++;
      end
      chk("rst_mid_acc_started", NI*DW'(acc_cnt), NI*DW'(1));
      reset = 1'b1;
      #1;
      chk("rst_mid_busy", NI*DW'(busy), '0);
      chk("rst_mid_acc_a", NI*DW'(acc_a), '0);
      chk("rst_mid_acc_b", NI*DW'(acc_b), '0);
      chk("rst_mid_tree_inputs", tree_inputs, '0);
      chk("rst_mid_result", NI*DW'(result), '0);
      chk("rst_mid_strobes", NI*DW'({done, tree_start, acc_start, chunk_ready}), '0);
      tick();
      reset = 1'b0;
      repeat (10) tick();
      $display("txn rst_mid: late acc_finish window done_pulses=%0d busy=%0b", done_cnt, busy);
      chk("rst_mid_late_finish_done", NI*DW'(done_cnt), '0);
      chk("rst_mid_late_finish_busy", NI*DW'(busy), '0);
      clear_counts();
      pulse_start(1);
      feed_chunk(32'h3F800000, "rst_after");
      wait_done_check("rst_after", 32'h41000000, 1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
